// File: rtl/resize_pool_core.sv
// resize_pool_core: centred crop of a 1-bit raster, FxF block set-pixel count, thresholded.
// Define RESIZE_POOL_HANDOFF_EN to add the HANDOFF_REQ/HANDOFF_ACK next-stage handshake.
module resize_pool_core #(
   parameter int P_WIDTH  = 320,
   parameter int P_HEIGHT = 240,
   parameter int P_CROP_W = 192,
   parameter int P_CROP_H = 192,
   parameter int P_FACTOR = 3,
   parameter int P_THR_W  = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               DIN_VALID,
   input  logic               DIN,
   input  logic [P_THR_W-1:0] THRESHOLD,
   output logic               OUT,
   output logic               VALID,
   output logic               OUT_LAST_IN_LINE,
   output logic               OUT_LAST_PIX,
   output logic               FRAME_LAST_PIX
`ifdef RESIZE_POOL_HANDOFF_EN
   ,
   output logic               HANDOFF_REQ,
   input  logic               HANDOFF_ACK
`endif
);

   localparam int OX  = (P_WIDTH - P_CROP_W) / 2;
   localparam int OY  = (P_HEIGHT - P_CROP_H) / 2;
   localparam int NOC = P_CROP_W / P_FACTOR;
   localparam int NOR = P_CROP_H / P_FACTOR;
   localparam int HW  = $clog2(P_WIDTH);
   localparam int VW  = $clog2(P_HEIGHT);
   localparam int BW  = $clog2(P_FACTOR);
   localparam int OCW = (NOC > 1) ? $clog2(NOC) : 1;
   localparam int ORW = (NOR > 1) ? $clog2(NOR) : 1;

   localparam logic [HW-1:0]  LP_H_LAST = HW'(P_WIDTH - 1);
   localparam logic [VW-1:0]  LP_V_LAST = VW'(P_HEIGHT - 1);
   localparam logic [HW-1:0]  LP_X0     = HW'(OX);
   localparam logic [HW-1:0]  LP_X1     = HW'(OX + P_CROP_W - 1);
   localparam logic [VW-1:0]  LP_Y0     = VW'(OY);
   localparam logic [VW-1:0]  LP_Y1     = VW'(OY + P_CROP_H - 1);
   localparam logic [BW-1:0]  LP_B_LAST = BW'(P_FACTOR - 1);
   localparam logic [OCW-1:0] LP_C_LAST = OCW'(NOC - 1);
   localparam logic [ORW-1:0] LP_R_LAST = ORW'(NOR - 1);

   logic [HW-1:0]      r_h;
   logic [VW-1:0]      r_v;
   logic [BW-1:0]      r_bc;
   logic [BW-1:0]      r_br;
   logic [OCW-1:0]     r_oc;
   logic [ORW-1:0]     r_orow;
   logic [P_THR_W-1:0] r_hsum;
   logic [P_THR_W-1:0] r_acc [NOC];

   logic               w_h_end;
   logic               w_v_end;
   logic               w_in_win;
   logic               w_bc_end;
   logic               w_br_end;
   logic               w_oc_end;
   logic               w_or_end;
   logic [P_THR_W-1:0] w_din;
   logic [P_THR_W-1:0] w_acc_rd;
   logic [P_THR_W-1:0] w_total;

   assign w_h_end  = (r_h == LP_H_LAST);
   assign w_v_end  = (r_v == LP_V_LAST);
   assign w_in_win = (r_h >= LP_X0) && (r_h <= LP_X1) &&
                     (r_v >= LP_Y0) && (r_v <= LP_Y1);
   assign w_bc_end = (r_bc == LP_B_LAST);
   assign w_br_end = (r_br == LP_B_LAST);
   assign w_oc_end = (r_oc == LP_C_LAST);
   assign w_or_end = (r_orow == LP_R_LAST);
   assign w_din    = {{(P_THR_W-1){1'b0}}, DIN};
   // First block row never reads acc, so stale contents need no clearing.
   assign w_acc_rd = (r_br == '0) ? '0 : r_acc[r_oc];
   assign w_total  = r_hsum + w_din + w_acc_rd;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_h              <= '0;
         r_v              <= '0;
         r_bc             <= '0;
         r_br             <= '0;
         r_oc             <= '0;
         r_orow           <= '0;
         r_hsum           <= '0;
         OUT              <= 1'b0;
         VALID            <= 1'b0;
         OUT_LAST_IN_LINE <= 1'b0;
         OUT_LAST_PIX     <= 1'b0;
         FRAME_LAST_PIX   <= 1'b0;
      end else begin
         VALID            <= 1'b0;
         OUT_LAST_IN_LINE <= 1'b0;
         OUT_LAST_PIX     <= 1'b0;
         FRAME_LAST_PIX   <= DIN_VALID && w_h_end && w_v_end;
         if (DIN_VALID) begin
            if (w_h_end) begin
               r_h <= '0;
               r_v <= w_v_end ? '0 : r_v + 1'b1;
            end else begin
               r_h <= r_h + 1'b1;
            end
            if (w_in_win) begin
               if (w_bc_end) begin
                  r_bc   <= '0;
                  r_hsum <= '0;
                  if (w_oc_end) begin
                     r_oc <= '0;
                     if (w_br_end) begin
                        r_br   <= '0;
                        r_orow <= w_or_end ? '0 : r_orow + 1'b1;
                     end else begin
                        r_br <= r_br + 1'b1;
                     end
                  end else begin
                     r_oc <= r_oc + 1'b1;
                  end
                  if (w_br_end) begin
                     VALID            <= 1'b1;
                     OUT              <= (w_total >= THRESHOLD);
                     OUT_LAST_IN_LINE <= w_oc_end;
                     OUT_LAST_PIX     <= w_oc_end && w_or_end;
                  end
               end else begin
                  r_bc   <= r_bc + 1'b1;
                  r_hsum <= r_hsum + w_din;
               end
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (DIN_VALID && w_in_win && w_bc_end && !w_br_end) begin
         r_acc[r_oc] <= w_total;
      end
   end

`ifdef RESIZE_POOL_HANDOFF_EN
   // A set coinciding with an ack wins: the frame just finished is still pending.
   always_ff @(posedge CLK) begin
      if (RST) begin
         HANDOFF_REQ <= 1'b0;
      end else if (OUT_LAST_PIX) begin
         HANDOFF_REQ <= 1'b1;
      end else if (HANDOFF_ACK) begin
         HANDOFF_REQ <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_resize_pool_core.sv
// tb_resize_pool_core: random and directed frames against a block-count image model.
// Exercises the handshake too when RESIZE_POOL_HANDOFF_EN is defined.
module tb_resize_pool_core;

   localparam int W    = 20;
   localparam int H    = 16;
   localparam int CW   = 12;
   localparam int CH   = 9;
   localparam int F    = 3;
   localparam int TW   = 4;
   localparam int OX   = (W - CW) / 2;
   localparam int OY   = (H - CH) / 2;
   localparam int NOC  = CW / F;
   localparam int NOR  = CH / F;
   localparam int NPIX = W * H;

   logic          CLK = 1'b0;
   logic          RST;
   logic          DIN_VALID;
   logic          DIN;
   logic [TW-1:0] THRESHOLD;
   logic          OUT;
   logic          VALID;
   logic          OUT_LAST_IN_LINE;
   logic          OUT_LAST_PIX;
   logic          FRAME_LAST_PIX;
`ifdef RESIZE_POOL_HANDOFF_EN
   logic          HANDOFF_REQ;
   logic          HANDOFF_ACK;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int gbeats = 0;
   int n_valid = 0;
   int n_exp = 0;
   int n_flp = 0;
   int n_frames = 0;
   bit img [H][W];
   logic [22:0] q_exp [$];

   resize_pool_core #(
      .P_WIDTH (W),
      .P_HEIGHT(H),
      .P_CROP_W(CW),
      .P_CROP_H(CH),
      .P_FACTOR(F),
      .P_THR_W (TW)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .DIN_VALID       (DIN_VALID),
      .DIN             (DIN),
      .THRESHOLD       (THRESHOLD),
      .OUT             (OUT),
      .VALID           (VALID),
      .OUT_LAST_IN_LINE(OUT_LAST_IN_LINE),
      .OUT_LAST_PIX    (OUT_LAST_PIX),
      .FRAME_LAST_PIX  (FRAME_LAST_PIX)
`ifdef RESIZE_POOL_HANDOFF_EN
      ,
      .HANDOFF_REQ     (HANDOFF_REQ),
      .HANDOFF_ACK     (HANDOFF_ACK)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Expected outputs: count each block of the image, tagged with the
   // running beat count at which its result must become visible.
   task automatic plan(input int thr, input int limit);
      for (int r = 0; r < NOR; r++) begin
         for (int c = 0; c < NOC; c++) begin
            int cnt = 0;
            int idx = (OY + r*F + F - 1) * W + OX + c*F + F - 1;
            for (int y = 0; y < F; y++)
               for (int x = 0; x < F; x++)
                  cnt += img[OY + r*F + y][OX + c*F + x];
            if (idx < limit) begin
               q_exp.push_back({cnt >= thr, c == NOC-1,
                                (c == NOC-1) && (r == NOR-1),
                                20'(gbeats + idx + 1)});
               n_exp++;
            end
         end
      end
   endtask

   task automatic drive(input int duty, input int limit);
      for (int p = 0; p < limit; p++) begin
         bit acc = 1'b0;
         while (!acc) begin
            acc       = ($urandom_range(99) < duty);
            DIN_VALID = acc;
            DIN       = acc ? img[p / W][p % W] : 1'($urandom);
            @(posedge CLK);
            #1;
         end
         gbeats++;
      end
      DIN_VALID = 1'b0;
      if (limit == NPIX) n_frames++;
   endtask

   task automatic frame(input int thr, input int duty);
      THRESHOLD = TW'(thr);
      plan(thr, NPIX);
      drive(duty, NPIX);
      repeat (4) @(posedge CLK);
      #1 chk("drain", q_exp.size(), 0);
   endtask

   task automatic do_reset();
      RST       = 1'b1;
      DIN_VALID = 1'b0;
      DIN       = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      gbeats = 0;
   endtask

   task automatic fill(input int mode);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            case (mode)
               0: img[y][x] = 1'b0;
               1: img[y][x] = 1'b1;
               2: img[y][x] = !(x >= OX && x < OX+CW && y >= OY && y < OY+CH);
               default: img[y][x] = ($urandom_range(99) < mode);
            endcase
   endtask

   always @(negedge CLK) begin
      if (!RST) begin
         if (VALID) begin
            n_valid++;
            if (q_exp.size() == 0)
               chk("spurious_valid", 32'(VALID), 0);
            else
               chk("pool_out", {OUT, OUT_LAST_IN_LINE, OUT_LAST_PIX,
                                20'(gbeats)}, q_exp.pop_front());
         end
         if (FRAME_LAST_PIX) begin
            n_flp++;
            chk("frame_last_pos", gbeats % NPIX, 0);
         end
      end
   end

   initial begin
      THRESHOLD = '0;
`ifdef RESIZE_POOL_HANDOFF_EN
      HANDOFF_ACK = 1'b0;
`endif
      do_reset();
      chk("rst_valid", VALID, 0);
      chk("rst_out", OUT, 0);
      chk("rst_lil", OUT_LAST_IN_LINE, 0);
      chk("rst_lp", OUT_LAST_PIX, 0);
      chk("rst_flp", FRAME_LAST_PIX, 0);
`ifdef RESIZE_POOL_HANDOFF_EN
      chk("rst_req", HANDOFF_REQ, 0);
`endif

      fill(1);
      frame(9, 100);

      fill(0);
      img[OY][OX]     = 1'b1;
      img[OY][OX+1]   = 1'b1;
      img[OY+1][OX+2] = 1'b1;
      img[OY+2][OX]   = 1'b1;
      img[OY+2][OX+2] = 1'b1;
      frame(5, 100);
      frame(6, 100);
      frame(0, 100);

      fill(2);
      frame(1, 100);

      for (int i = 0; i < 4; i++) begin
         fill(20 + 20*i);
         frame($urandom_range(10), 30);
      end

      fill(1);
      THRESHOLD = TW'(9);
      plan(9, 6*W + 7);
      drive(100, 6*W + 7);
      repeat (3) @(posedge CLK);
      #1 chk("partial_drain", q_exp.size(), 0);
      do_reset();
      frame(9, 100);

`ifdef RESIZE_POOL_HANDOFF_EN
      fill(1);
      THRESHOLD = TW'(9);
      plan(9, NPIX);
      fork
         drive(100, NPIX);
         begin
            bit seen = 1'b0;
            for (int k = 0; k < 2000 && !seen; k++) begin
               @(negedge CLK);
               if (VALID && OUT_LAST_PIX) seen = 1'b1;
            end
            chk("olp_seen", 32'(seen), 1);
            chk("req_before", HANDOFF_REQ, 0);
            HANDOFF_ACK = 1'b1;
            @(posedge CLK);
            #1 HANDOFF_ACK = 1'b0;
            chk("req_set_ack", HANDOFF_REQ, 1);
            repeat (3) @(posedge CLK);
            #1 chk("req_hold", HANDOFF_REQ, 1);
            HANDOFF_ACK = 1'b1;
            @(posedge CLK);
            #1 HANDOFF_ACK = 1'b0;
            chk("req_clear", HANDOFF_REQ, 0);
         end
      join
      repeat (4) @(posedge CLK);
      #1 chk("hs_drain", q_exp.size(), 0);
`endif

      chk("valid_count", n_valid, n_exp);
      chk("flp_count", n_flp, n_frames);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
